// File: rtl/i2c_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : i2c_pkg
//  Description : Shared I2C definitions: bus-protocol state encoding and the
//                ACK/NACK bit values seen on SDA during the 9th clock.
//  Revision    : 1.0 - initial release
// ============================================================================
package i2c_pkg;

    // Protocol phases of an EEPROM-style I2C target
    typedef enum logic [3:0] {
        IDLE     = 4'd0,
        DEV      = 4'd1,
        DEV_ACK  = 4'd2,
        AH       = 4'd3,
        AH_ACK   = 4'd4,
        AL       = 4'd5,
        AL_ACK   = 4'd6,
        WDAT     = 4'd7,
        WDAT_ACK = 4'd8,
        RDAT     = 4'd9,
        RDAT_ACK = 4'd10
    } i2c_state_e;

    // Level on SDA during the acknowledge bit
    localparam logic c_ACK  = 1'b0;
    localparam logic c_NACK = 1'b1;

    // Data bits per byte before the acknowledge slot
    localparam logic [3:0] c_BITS_PER_BYTE = 4'd8;

endpackage : i2c_pkg
`default_nettype wire

// File: rtl/i2c_eeprom_mem.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : i2c_eeprom_mem
//  Description : Byte-wide storage, one synchronous write port and one
//                synchronous read port. Contents survive reset.
//  Revision    : 1.0 - initial release
// ============================================================================
module i2c_eeprom_mem #(
    parameter int MEM_AW = 8
) (
    input  logic              clk,
    input  logic              we_i,
    input  logic [MEM_AW-1:0] waddr_i,
    input  logic [7:0]        wdata_i,
    input  logic [MEM_AW-1:0] raddr_i,
    output logic [7:0]        rdata_o
);

    logic [7:0] mem_q [2**MEM_AW];

    // Write on request; read data is registered one clock after the address
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
        rdata_o <= mem_q[raddr_i];
    end

endmodule : i2c_eeprom_mem
`default_nettype wire

// File: rtl/i2c_eeprom_target.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : i2c_eeprom_target
//  Description : I2C target emulating a 16-bit-addressed EEPROM. Supports
//                byte/page writes, random, current-address and sequential
//                reads. SCL/SDA are oversampled by the system clock.
//  Revision    : 1.0 - initial release
// ============================================================================
module i2c_eeprom_target #(
    parameter logic [6:0] DEV_ADDR = 7'h50,
    parameter int         MEM_AW   = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        SCL,
    inout  wire         SDA,
    output logic        busy,
    output logic        wr_pulse,
    output logic [15:0] wr_addr,
    output logic [7:0]  wr_byte
);
    import i2c_pkg::*;

    // Synchronizer chains; stage 3 is the previous synchronized value
    logic scl_s1_q, scl_s2_q, scl_s3_q;
    logic sda_s1_q, sda_s2_q, sda_s3_q;

    logic w_scl_rise, w_scl_fall, w_start, w_stop, w_we;
    logic [7:0] w_rdata;

    i2c_state_e  state_q;
    logic [3:0]  cnt_q;
    logic [7:0]  shift_q;
    logic [15:0] ptr_q;
    logic        rw_q;
    logic        ack_q;
    logic        sda_oe_q;
    logic        busy_q;
    logic        wr_pulse_q;
    logic [15:0] wr_addr_q;
    logic [7:0]  wr_byte_q;

    // Bring the asynchronous bus lines into the clk domain
    always_ff @(posedge clk) begin
        if (rst) begin
            {scl_s1_q, scl_s2_q, scl_s3_q} <= 3'b111;
            {sda_s1_q, sda_s2_q, sda_s3_q} <= 3'b111;
        end else begin
            {scl_s1_q, scl_s2_q, scl_s3_q} <= {SCL, scl_s1_q, scl_s2_q};
            {sda_s1_q, sda_s2_q, sda_s3_q} <= {SDA, sda_s1_q, sda_s2_q};
        end
    end

    assign w_scl_rise = scl_s2_q & ~scl_s3_q;
    assign w_scl_fall = ~scl_s2_q & scl_s3_q;
    // Bus conditions: SDA moving while SCL stays high
    assign w_start    = scl_s2_q & scl_s3_q & ~sda_s2_q &  sda_s3_q;
    assign w_stop     = scl_s2_q & scl_s3_q &  sda_s2_q & ~sda_s3_q;

    // Commit the data byte on the 9th SCL rise, i.e. only once it was fully received
    assign w_we = (state_q == WDAT_ACK) & w_scl_rise;

    // Open-drain output: never drive a 1
    assign SDA      = sda_oe_q ? 1'b0 : 1'bz;
    assign busy     = busy_q;
    assign wr_pulse = wr_pulse_q;
    assign wr_addr  = wr_addr_q;
    assign wr_byte  = wr_byte_q;

    i2c_eeprom_mem #(
        .MEM_AW (MEM_AW)
    ) u_mem (
        .clk     (clk),
        .we_i    (w_we),
        .waddr_i (ptr_q[MEM_AW-1:0]),
        .wdata_i (shift_q),
        .raddr_i (ptr_q[MEM_AW-1:0]),
        .rdata_o (w_rdata)
    );

    // Protocol FSM: START/STOP take priority over any bit activity
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= 4'd0;
            shift_q    <= 8'h00;
            ptr_q      <= 16'h0000;
            rw_q       <= 1'b0;
            ack_q      <= c_NACK;
            sda_oe_q   <= 1'b0;
            busy_q     <= 1'b0;
            wr_pulse_q <= 1'b0;
            wr_addr_q  <= 16'h0000;
            wr_byte_q  <= 8'h00;
        end else begin
            wr_pulse_q <= 1'b0;
            if (w_start) begin
                state_q  <= DEV;
                cnt_q    <= 4'd0;
                sda_oe_q <= 1'b0;
                busy_q   <= 1'b0;
            end else if (w_stop) begin
                state_q  <= IDLE;
                cnt_q    <= 4'd0;
                sda_oe_q <= 1'b0;
                busy_q   <= 1'b0;
            end else begin
                case (state_q)
                    IDLE: begin
                        sda_oe_q <= 1'b0;
                    end
                    DEV, AH, AL, WDAT: begin
                        if (w_scl_rise) begin
                            shift_q <= {shift_q[6:0], sda_s2_q};
                            cnt_q   <= cnt_q + 4'd1;
                        end else if (w_scl_fall && cnt_q == c_BITS_PER_BYTE) begin
                            cnt_q    <= 4'd0;
                            sda_oe_q <= 1'b1;
                            case (state_q)
                                DEV: begin
                                    if (shift_q[7:1] == DEV_ADDR) begin
                                        state_q <= DEV_ACK;
                                        rw_q    <= shift_q[0];
                                        busy_q  <= 1'b1;
                                    end else begin
                                        // Not ours: stay off the bus until the next START
                                        state_q  <= IDLE;
                                        sda_oe_q <= 1'b0;
                                    end
                                end
                                AH: begin
                                    ptr_q[15:8] <= shift_q;
                                    state_q     <= AH_ACK;
                                end
                                AL: begin
                                    ptr_q[7:0] <= shift_q;
                                    state_q    <= AL_ACK;
                                end
                                default: begin
                                    state_q <= WDAT_ACK;
                                end
                            endcase
                        end
                    end
                    DEV_ACK, AH_ACK, AL_ACK, WDAT_ACK: begin
                        if (w_we) begin
                            wr_pulse_q <= 1'b1;
                            wr_addr_q  <= ptr_q;
                            wr_byte_q  <= shift_q;
                            ptr_q      <= ptr_q + 16'd1;
                        end else if (w_scl_fall) begin
                            sda_oe_q <= 1'b0;
                            cnt_q    <= 4'd0;
                            case (state_q)
                                DEV_ACK: begin
                                    if (rw_q) begin
                                        // First read bit goes out on this same fall
                                        state_q  <= RDAT;
                                        shift_q  <= w_rdata;
                                        sda_oe_q <= ~w_rdata[7];
                                    end else begin
                                        state_q <= AH;
                                    end
                                end
                                AH_ACK:  state_q <= AL;
                                default: state_q <= WDAT;
                            endcase
                        end
                    end
                    RDAT: begin
                        if (w_scl_rise) begin
                            shift_q <= {shift_q[6:0], 1'b0};
                            cnt_q   <= cnt_q + 4'd1;
                        end else if (w_scl_fall) begin
                            if (cnt_q == c_BITS_PER_BYTE) begin
                                state_q  <= RDAT_ACK;
                                sda_oe_q <= 1'b0;
                            end else begin
                                sda_oe_q <= ~shift_q[7];
                            end
                        end
                    end
                    RDAT_ACK: begin
                        if (w_scl_rise) begin
                            // Advance now so the read port has the next byte by the fall
                            ack_q <= sda_s2_q;
                            ptr_q <= ptr_q + 16'd1;
                        end else if (w_scl_fall) begin
                            cnt_q <= 4'd0;
                            if (ack_q == c_ACK) begin
                                state_q  <= RDAT;
                                shift_q  <= w_rdata;
                                sda_oe_q <= ~w_rdata[7];
                            end else begin
                                state_q  <= IDLE;
                                sda_oe_q <= 1'b0;
                            end
                        end
                    end
                    default: begin
                        state_q  <= IDLE;
                        sda_oe_q <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule : i2c_eeprom_target
`default_nettype wire

// File: tb/tb_i2c_eeprom_target.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_i2c_eeprom_target
//  Description : Self-checking bench: 200 kHz I2C initiator with SDA pull-up,
//                EEPROM reference model built from pointer/byte semantics.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_i2c_eeprom_target;

    localparam int c_CLK_HALF = 10;     // 50 MHz system clock
    localparam int c_Q        = 1250;   // quarter of a 5 us SCL period

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        scl_tb = 1'b1;
    logic        sda_low = 1'b0;
    wire         SDA;
    logic        busy;
    logic        wr_pulse;
    logic [15:0] wr_addr;
    logic [7:0]  wr_byte;

    int n_checks = 0;
    int n_fail   = 0;

    pullup (SDA);
    assign SDA = sda_low ? 1'b0 : 1'bz;

    i2c_eeprom_target #(
        .DEV_ADDR (7'h50),
        .MEM_AW   (8)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .SCL      (scl_tb),
        .SDA      (SDA),
        .busy     (busy),
        .wr_pulse (wr_pulse),
        .wr_addr  (wr_addr),
        .wr_byte  (wr_byte)
    );

    always #c_CLK_HALF clk = ~clk;

    // ---------------- reference model: byte array plus a 16-bit pointer ----
    logic [7:0]  mem_m [256];
    int          ptr_m = 0;
    logic [15:0] exp_a_q [$];
    logic [7:0]  exp_b_q [$];

    function automatic void m_write(input logic [7:0] d);
        mem_m[ptr_m % 256] = d;
        exp_a_q.push_back(16'(ptr_m));
        exp_b_q.push_back(d);
        ptr_m = (ptr_m + 1) % 65536;
    endfunction

    function automatic logic [7:0] m_read();
        logic [7:0] d;
        d     = mem_m[ptr_m % 256];
        ptr_m = (ptr_m + 1) % 65536;
        return d;
    endfunction

    // Observed commits, sampled away from the active edge
    logic [15:0] got_a_q [$];
    logic [7:0]  got_b_q [$];
    always @(negedge clk) begin
        if (wr_pulse === 1'b1) begin
            got_a_q.push_back(wr_addr);
            got_b_q.push_back(wr_byte);
        end
    end

    // ---------------- initiator bus primitives ----------------------------
    task automatic bus_start();
        sda_low = 1'b0; #(c_Q);
        scl_tb  = 1'b1; #(c_Q);
        sda_low = 1'b1; #(c_Q);
        scl_tb  = 1'b0; #(c_Q);
    endtask

    task automatic bus_stop();
        sda_low = 1'b1; #(c_Q);
        scl_tb  = 1'b1; #(c_Q);
        sda_low = 1'b0; #(2 * c_Q);
    endtask

    task automatic send_bit(input logic b);
        sda_low = ~b;   #(c_Q);
        scl_tb  = 1'b1; #(2 * c_Q);
        scl_tb  = 1'b0; #(c_Q);
    endtask

    task automatic recv_bit(output logic b);
        sda_low = 1'b0; #(c_Q);
        scl_tb  = 1'b1; #(c_Q);
        b = SDA;        #(c_Q);
        scl_tb  = 1'b0; #(c_Q);
    endtask

    task automatic send_byte(input logic [7:0] d, output logic ack);
        for (int i = 7; i >= 0; i--) send_bit(d[i]);
        recv_bit(ack);
    endtask

    task automatic recv_byte(input logic nack, output logic [7:0] d);
        logic b;
        for (int i = 7; i >= 0; i--) begin
            recv_bit(b);
            d[i] = b;
        end
        send_bit(nack);
    endtask

    task automatic clear_queues();
        exp_a_q.delete(); exp_b_q.delete();
        got_a_q.delete(); got_b_q.delete();
    endtask

    // ---------------- scenarios ------------------------------------------
    task automatic test_reset();
        rst = 1'b1;
        repeat (4) @(negedge clk);
        rst = 1'b0;
        ptr_m = 0;
        repeat (4) @(negedge clk);
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
        n_checks++; if (wr_pulse !== 1'b0) begin n_fail++; $display("FAIL reset_wr_pulse: got %b expected 0", wr_pulse); end
        n_checks++; if (wr_addr !== 16'h0000) begin n_fail++; $display("FAIL reset_wr_addr: got %h expected 0000", wr_addr); end
        n_checks++; if (wr_byte !== 8'h00) begin n_fail++; $display("FAIL reset_wr_byte: got %h expected 00", wr_byte); end
        n_checks++; if (SDA !== 1'b1) begin n_fail++; $display("FAIL reset_sda: got %b expected 1", SDA); end
    endtask

    task automatic test_write();
        logic [3:0] acks;
        logic [7:0] bytes [4];
        bytes = '{8'hA0, 8'h00, 8'h12, 8'hA5};
        clear_queues();
        bus_start();
        for (int i = 0; i < 4; i++) send_byte(bytes[i], acks[i]);
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL write_busy_active: got %b expected 1", busy); end
        bus_stop();
        ptr_m = 16'h0012;
        m_write(8'hA5);
        #(c_Q);
        n_checks++; if (acks !== 4'b0000) begin n_fail++; $display("FAIL write_acks: got %b expected 0000", acks); end
        n_checks++; if (got_a_q.size() != exp_a_q.size()) begin n_fail++; $display("FAIL write_pulse_count: got %0d expected %0d", got_a_q.size(), exp_a_q.size()); end
        for (int i = 0; i < exp_a_q.size() && i < got_a_q.size(); i++) begin
            n_checks++; if (got_a_q[i] !== exp_a_q[i]) begin n_fail++; $display("FAIL write_addr: got %h expected %h", got_a_q[i], exp_a_q[i]); end
            n_checks++; if (got_b_q[i] !== exp_b_q[i]) begin n_fail++; $display("FAIL write_byte: got %h expected %h", got_b_q[i], exp_b_q[i]); end
        end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL write_busy_after_stop: got %b expected 0", busy); end
    endtask

    task automatic test_random_read();
        logic [3:0] acks;
        logic [7:0] d, e;
        clear_queues();
        bus_start();
        send_byte(8'hA0, acks[0]);
        send_byte(8'h00, acks[1]);
        send_byte(8'h12, acks[2]);
        bus_start();
        send_byte(8'hA1, acks[3]);
        recv_byte(1'b1, d);
        bus_stop();
        ptr_m = 16'h0012;
        e = m_read();
        n_checks++; if (acks !== 4'b0000) begin n_fail++; $display("FAIL rread_acks: got %b expected 0000", acks); end
        n_checks++; if (d !== e) begin n_fail++; $display("FAIL rread_data: got %h expected %h", d, e); end
        n_checks++; if (got_a_q.size() != 0) begin n_fail++; $display("FAIL rread_no_write: got %0d pulses expected 0", got_a_q.size()); end
    endtask

    task automatic test_addr_miss();
        logic       ack0, ack1;
        logic [6:0] a;
        clear_queues();
        a = 7'($urandom_range(0, 127));
        if (a == 7'h50) a = 7'h51;
        bus_start();
        send_byte({a, 1'b0}, ack0);
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL miss_busy: got %b expected 0", busy); end
        send_byte(8'($urandom_range(0, 255)), ack1);
        bus_stop();
        #(c_Q);
        n_checks++; if (ack0 !== 1'b1) begin n_fail++; $display("FAIL miss_dev_ack: got %b expected 1 (addr %h)", ack0, a); end
        n_checks++; if (ack1 !== 1'b1) begin n_fail++; $display("FAIL miss_next_ack: got %b expected 1", ack1); end
        n_checks++; if (got_a_q.size() != 0) begin n_fail++; $display("FAIL miss_no_write: got %0d pulses expected 0", got_a_q.size()); end
    endtask

    task automatic test_burst_abort();
        logic [4:0] acks;
        logic [7:0] r0, r1, part;
        clear_queues();
        r0   = 8'($urandom_range(0, 255));
        r1   = 8'($urandom_range(0, 255));
        part = 8'($urandom_range(0, 255));
        bus_start();
        send_byte(8'hA0, acks[0]);
        send_byte(8'h00, acks[1]);
        send_byte(8'hFF, acks[2]);
        send_byte(r0,    acks[3]);
        send_byte(r1,    acks[4]);
        for (int i = 7; i >= 4; i--) send_bit(part[i]);
        bus_stop();
        ptr_m = 16'h00FF;
        m_write(r0);
        m_write(r1);
        #(c_Q);
        n_checks++; if (acks !== 5'b00000) begin n_fail++; $display("FAIL burst_acks: got %b expected 00000", acks); end
        n_checks++; if (got_a_q.size() != exp_a_q.size()) begin n_fail++; $display("FAIL burst_pulse_count: got %0d expected %0d", got_a_q.size(), exp_a_q.size()); end
        for (int i = 0; i < exp_a_q.size() && i < got_a_q.size(); i++) begin
            n_checks++; if (got_a_q[i] !== exp_a_q[i]) begin n_fail++; $display("FAIL burst_addr[%0d]: got %h expected %h", i, got_a_q[i], exp_a_q[i]); end
            n_checks++; if (got_b_q[i] !== exp_b_q[i]) begin n_fail++; $display("FAIL burst_byte[%0d]: got %h expected %h", i, got_b_q[i], exp_b_q[i]); end
        end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL abort_busy: got %b expected 0", busy); end
    endtask

    task automatic test_wrap_read();
        logic [3:0] acks;
        logic [7:0] d0, d1, e0, e1;
        clear_queues();
        bus_start();
        send_byte(8'hA0, acks[0]);
        send_byte(8'h00, acks[1]);
        send_byte(8'hFF, acks[2]);
        bus_start();
        send_byte(8'hA1, acks[3]);
        recv_byte(1'b0, d0);
        recv_byte(1'b1, d1);
        bus_stop();
        ptr_m = 16'h00FF;
        e0 = m_read();
        e1 = m_read();
        n_checks++; if (acks !== 4'b0000) begin n_fail++; $display("FAIL wrap_acks: got %b expected 0000", acks); end
        n_checks++; if (d0 !== e0) begin n_fail++; $display("FAIL wrap_byte0: got %h expected %h", d0, e0); end
        n_checks++; if (d1 !== e1) begin n_fail++; $display("FAIL wrap_byte1: got %h expected %h", d1, e1); end
    endtask

    task automatic test_reset_during_ack();
        logic       ack;
        logic [7:0] d, e;
        logic [7:0] dev;
        dev = 8'hA0;
        bus_start();
        for (int i = 7; i >= 0; i--) send_bit(dev[i]);
        sda_low = 1'b0;
        #1;
        n_checks++; if (SDA !== 1'b0) begin n_fail++; $display("FAIL ackrst_pre_sda: got %b expected 0", SDA); end
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL ackrst_pre_busy: got %b expected 1", busy); end
        @(negedge clk) rst = 1'b1;
        @(negedge clk) rst = 1'b0;
        ptr_m = 0;
        n_checks++; if (SDA !== 1'b1) begin n_fail++; $display("FAIL ackrst_sda: got %b expected 1", SDA); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL ackrst_busy: got %b expected 0", busy); end
        bus_stop();
        // Pointer restarts at zero while memory keeps its contents
        bus_start();
        send_byte(8'hA1, ack);
        recv_byte(1'b1, d);
        bus_stop();
        e = m_read();
        n_checks++; if (ack !== 1'b0) begin n_fail++; $display("FAIL ackrst_cur_ack: got %b expected 0", ack); end
        n_checks++; if (d !== e) begin n_fail++; $display("FAIL ackrst_cur_data: got %h expected %h", d, e); end
    endtask

    // Hard time limit: the run must never hang
    initial begin
        #(1_900_000);
        $display("FAIL watchdog: got timeout, expected completion before time limit");
        $fatal(1, "time limit reached");
    end

    initial begin
        test_reset();
        test_write();
        test_random_read();
        test_addr_miss();
        test_burst_abort();
        test_wrap_read();
        test_reset_during_ack();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_i2c_eeprom_target
`default_nettype wire
